// File: rtl/fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data and
// programmable almost-full / almost-empty flags.
module fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_WIDTH = 8
) (
    input  logic                  FIFO_CLK,
    input  logic                  RST_N,
    input  logic                  FIFO_WR_ENA,
    input  logic [FIFO_WIDTH-1:0] FIFO_WR_DATA,
    input  logic                  FIFO_WR_LAST,
    output logic                  FIFO_WR_FULL,
    output logic                  FIFO_WR_ALM_FULL,
    input  logic [FIFO_DEPTH-1:0] FIFO_WR_ALM_COUNT,
    input  logic                  FIFO_RD_ENA,
    output logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_EMPTY,
    output logic                  FIFO_RD_ALM_EMPTY,
    input  logic [FIFO_DEPTH-1:0] FIFO_RD_ALM_COUNT
);

    localparam int unsigned ENTRIES = 2 ** FIFO_DEPTH;
    localparam int unsigned CNT_W   = FIFO_DEPTH + 1;

    logic [FIFO_WIDTH-1:0] mem [ENTRIES];
    logic [FIFO_DEPTH-1:0] wptr;
    logic [FIFO_DEPTH-1:0] rptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_last_unused;

    // End-of-packet tag is reserved for a future packet mode.
    assign wr_last_unused = FIFO_WR_LAST;

    assign wr_ok = FIFO_WR_ENA & ~FIFO_WR_FULL;
    assign rd_ok = FIFO_RD_ENA & ~FIFO_RD_EMPTY;

    // Pointer and occupancy tracking.
    always_ff @(posedge FIFO_CLK) begin
        if (!RST_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + FIFO_DEPTH'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + FIFO_DEPTH'(1);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_W'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is not reset; a write on a reset edge is suppressed.
    always_ff @(posedge FIFO_CLK) begin
        if (RST_N && wr_ok) begin
            mem[wptr] <= FIFO_WR_DATA;
        end
    end

    assign FIFO_WR_FULL      = (count == CNT_W'(ENTRIES));
    assign FIFO_RD_EMPTY     = (count == '0);
    assign FIFO_WR_ALM_FULL  = ((CNT_W'(ENTRIES) - count) <= CNT_W'(FIFO_WR_ALM_COUNT));
    assign FIFO_RD_ALM_EMPTY = (count <= CNT_W'(FIFO_RD_ALM_COUNT));
    assign FIFO_RD_DATA      = FIFO_RD_EMPTY ? '0 : mem[rptr];

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for the FWFT byte FIFO: a queue model tracks the contents
// and every cycle the flags and head data are compared against it.
module tb_fifo;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned ENTRIES = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_ena;
    logic [WIDTH-1:0] wr_data;
    logic             wr_last;
    logic             wr_full;
    logic             wr_alm_full;
    logic [DEPTH-1:0] wr_alm_count;
    logic             rd_ena;
    logic [WIDTH-1:0] rd_data;
    logic             rd_empty;
    logic             rd_alm_empty;
    logic [DEPTH-1:0] rd_alm_count;

    int               checks = 0;
    int               errors = 0;
    int               popped = 0;
    logic [WIDTH-1:0] sb_q[$];

    always #5 clk = ~clk;

    fifo #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) dut (
        .FIFO_CLK          (clk),
        .RST_N             (rst_n),
        .FIFO_WR_ENA       (wr_ena),
        .FIFO_WR_DATA      (wr_data),
        .FIFO_WR_LAST      (wr_last),
        .FIFO_WR_FULL      (wr_full),
        .FIFO_WR_ALM_FULL  (wr_alm_full),
        .FIFO_WR_ALM_COUNT (wr_alm_count),
        .FIFO_RD_ENA       (rd_ena),
        .FIFO_RD_DATA      (rd_data),
        .FIFO_RD_EMPTY     (rd_empty),
        .FIFO_RD_ALM_EMPTY (rd_alm_empty),
        .FIFO_RD_ALM_COUNT (rd_alm_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare flags and head-of-queue data against the model occupancy.
    task automatic check_state(input string tag);
        int               n;
        logic [WIDTH-1:0] head;
        n    = sb_q.size();
        head = (n == 0) ? '0 : sb_q[0];
        check({tag, ":empty"},     32'(rd_empty),     32'(n == 0));
        check({tag, ":full"},      32'(wr_full),      32'(n == ENTRIES));
        check({tag, ":alm_full"},  32'(wr_alm_full),  32'((ENTRIES - n) <= int'(wr_alm_count)));
        check({tag, ":alm_empty"}, 32'(rd_alm_empty), 32'(n <= int'(rd_alm_count)));
        check({tag, ":rd_data"},   32'(rd_data),      32'(head));
    endtask

    // One clock: drive, compare popped data, advance the model, recheck state.
    task automatic cycle(input string tag, input logic wr, input logic [WIDTH-1:0] d,
                         input logic rd, input logic last);
        logic wok;
        logic rok;
        wr_ena  = wr;
        wr_data = d;
        rd_ena  = rd;
        wr_last = last;
        wok = wr && (sb_q.size() < ENTRIES);
        rok = rd && (sb_q.size() > 0);
        if (rok) begin
            check({tag, ":pop"}, 32'(rd_data), 32'(sb_q[0]));
        end
        @(posedge clk);
        if (rok) begin
            void'(sb_q.pop_front());
            popped++;
        end
        if (wok) begin
            sb_q.push_back(d);
        end
        #1;
        wr_ena  = 1'b0;
        rd_ena  = 1'b0;
        wr_last = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input int n, input logic wr);
        rst_n   = 1'b0;
        wr_ena  = wr;
        wr_data = 8'h99;
        rd_ena  = wr;
        repeat (n) @(posedge clk);
        sb_q.delete();
        #1;
        rst_n  = 1'b1;
        wr_ena = 1'b0;
        rd_ena = 1'b0;
        check_state("reset");
    endtask

    initial begin
        int sent;
        int cyc;
        int popped_base;
        rst_n        = 1'b0;
        wr_ena       = 1'b0;
        wr_data      = '0;
        wr_last      = 1'b0;
        rd_ena       = 1'b0;
        wr_alm_count = 4'd1;
        rd_alm_count = 4'd1;
        #1;

        // Test 1: reset
        do_reset(4, 1'b0);
        check("reset_count", 32'(rd_empty), 32'd1);

        // Test 2: fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) begin
            cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        end
        cycle("overflow", 1'b1, 8'hAA, 1'b0, 1'b0);
        check("full_after_drop", 32'(wr_full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        end
        cycle("underflow", 1'b0, '0, 1'b1, 1'b0);
        check("popped_16", 32'(popped), 32'd16);

        // Test 3: single write into empty FIFO
        cycle("single", 1'b1, 8'h5A, 1'b0, 1'b0);
        check("single_data", 32'(rd_data), 32'h5A);
        cycle("second", 1'b1, 8'h5B, 1'b0, 1'b0);

        // Test 4: simultaneous write and read with other thresholds
        wr_alm_count = 4'd6;
        rd_alm_count = 4'd9;
        for (int i = 0; i < 6; i++) begin
            cycle("to8", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle("wr_rd_8", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        end
        while (sb_q.size() > 0) cycle("drain4", 1'b0, '0, 1'b1, 1'b0);
        cycle("wr_rd_empty", 1'b1, 8'h77, 1'b1, 1'b0);
        check("wr_rd_empty_data", 32'(rd_data), 32'h77);
        for (int i = 0; i < 15; i++) begin
            cycle("to16", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        cycle("wr_rd_full", 1'b1, 8'hEE, 1'b1, 1'b0);
        check("wr_rd_full_notfull", 32'(wr_full), 32'd0);
        while (sb_q.size() > 0) cycle("drain4b", 1'b0, '0, 1'b1, 1'b0);

        // Test 5: slow writer, greedy reader, many wraps
        wr_alm_count = 4'd0;
        rd_alm_count = 4'd0;
        popped_base  = popped;
        sent = 0;
        cyc  = 0;
        while (sent < 256) begin
            if (cyc % 5 == 0) begin
                cycle("stream", 1'b1, 8'(sent), 1'b1, (sent % 16) == 15);
                sent++;
            end else begin
                cycle("stream", 1'b0, '0, 1'b1, 1'b0);
            end
            cyc++;
        end
        repeat (3) cycle("stream_tail", 1'b0, '0, 1'b1, 1'b0);
        check("stream_count", 32'(popped - popped_base), 32'd256);

        // Test 6: reset mid-operation
        wr_alm_count = 4'd1;
        rd_alm_count = 4'd1;
        for (int i = 0; i < 10; i++) begin
            cycle("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        do_reset(1, 1'b1);
        check("mid_rst_data", 32'(rd_data), 32'h0);
        cycle("post_rst_wr", 1'b1, 8'h33, 1'b0, 1'b0);
        cycle("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
Single-clock synchronous byte FIFO with first-word-fall-through read, full/empty flags and programmable almost-full/almost-empty flags. It buffers a byte stream between a producer and a consumer in the same clock domain, for example between the UART debug datapath and the host-side logic. The producer may tag a byte with a "last" marker; that marker is reserved and is not stored.

Parameters:
FIFO_DEPTH  4  address width; capacity = 2**FIFO_DEPTH entries (16)
FIFO_WIDTH  8  data width in bits

Ports:
FIFO_CLK  in  1  single clock for both write and read sides, rising edge
RST_N  in  1  reset; synchronous, active-low
FIFO_WR_ENA  in  1  write request
FIFO_WR_DATA  in  FIFO_WIDTH  write data
FIFO_WR_LAST  in  1  end-of-packet tag; reserved, no effect
FIFO_WR_FULL  out  1  FIFO holds 2**FIFO_DEPTH entries
FIFO_WR_ALM_FULL  out  1  free entries <= FIFO_WR_ALM_COUNT
FIFO_WR_ALM_COUNT  in  FIFO_DEPTH  almost-full threshold, in free entries
FIFO_RD_ENA  in  1  read/pop request
FIFO_RD_DATA  out  FIFO_WIDTH  head-of-queue data (FWFT)
FIFO_RD_EMPTY  out  1  FIFO holds 0 entries
FIFO_RD_ALM_EMPTY  out  1  stored entries <= FIFO_RD_ALM_COUNT
FIFO_RD_ALM_COUNT  in  FIFO_DEPTH  almost-empty threshold, in stored entries

Behaviour:
- State:
  - Storage memory of 2**FIFO_DEPTH x FIFO_WIDTH (not reset).
  - Write pointer and read pointer, each FIFO_DEPTH bits, wrapping modulo 2**FIFO_DEPTH.
  - Occupancy counter `count`, FIFO_DEPTH+1 bits, range 0..2**FIFO_DEPTH.
- Reset: at a rising edge with RST_N=0, the pointers and `count` go to 0. Resulting output values:
  - EMPTY=1, FULL=0, ALM_EMPTY=1, ALM_FULL=0.
  - RD_DATA=0.
- Reset mid-operation discards all contents; no write or read is performed on the reset edge.
- Write acceptance: wr_ok = FIFO_WR_ENA & ~FULL, with FULL sampled before the edge.
  - On the edge, mem[wptr] <= WR_DATA and wptr increments.
  - A write while full is dropped silently, even if a read happens on the same edge.
- Read acceptance: rd_ok = FIFO_RD_ENA & ~EMPTY.
  - On the edge, rptr increments.
  - A read while empty is ignored, even if a write happens on the same edge.
- Count update per edge:
  - +1 if wr_ok only.
  - -1 if rd_ok only.
  - Unchanged if both or neither.
- Simultaneous write and read when 0 < count < 2**FIFO_DEPTH: both take effect.
- FWFT read data:
  - FIFO_RD_DATA = mem[rptr] combinationally whenever count > 0, forced to 0 when empty.
  - The consumer samples RD_DATA together with asserting RD_ENA; the pop takes effect at that edge.
  - The next entry is visible immediately after the edge.
- Latency: a byte written at edge N is visible on RD_DATA and clears EMPTY after edge N (usable at edge N+1).
- Flags are combinational from the registered `count` and the threshold inputs, so they update in the cycle after the causing edge:
  - FULL = (count == 2**FIFO_DEPTH).
  - EMPTY = (count == 0).
  - ALM_FULL = ((2**FIFO_DEPTH - count) <= WR_ALM_COUNT).
  - ALM_EMPTY = (count <= RD_ALM_COUNT).
  - Threshold compares are unsigned, at FIFO_DEPTH+1 bits.
- Ordering: strict FIFO order is preserved across pointer wrap-around.
- FIFO_WR_LAST: accepted, not stored, no effect on flags or data.

Test Plan:
1. Reset with RST_N=0 for 4 clocks, ALM counts = 1 -> EMPTY=1, FULL=0, ALM_EMPTY=1, ALM_FULL=0, RD_DATA=0.
2. Write 0x00..0x0F without reading:
   - ALM_FULL rises after the 15th write.
   - FULL rises after the 16th write.
   - A 17th write of 0xAA is dropped.
   - Then read 16 times -> data 0x00..0x0F in order; EMPTY after the last read; a further read is ignored.
3. Single write 0x5A into an empty FIFO -> after the edge, EMPTY=0, RD_DATA=0x5A, ALM_EMPTY=1 (count 1 <= 1); after a second write, ALM_EMPTY=0.
4. Simultaneous write and read:
   - At count 8 -> count stays 8 and order is preserved.
   - When empty with WR+RD -> count becomes 1, data intact.
   - When full with WR+RD -> count becomes 15, the write is dropped.
5. Stream 256 bytes 0x00..0xFF with a slow writer (every 5th clock) and a greedy reader, WR_LAST every 16th byte -> the reader sees 0x00..0xFF in exact order across many pointer wraps, with no errors.
6. Reset asserted with count 10 -> on the next cycle count is 0, EMPTY=1, RD_DATA=0; a subsequent write 0x33 and read return 0x33.
